// File: rtl/pipe_stage_reg.sv
// Parametrised valid/ready pipeline stage register with flush and stall counter.
// Define PIPE_SKID_EN for a two-entry skid stage with registered in_ready.
module pipe_stage_reg #(
  parameter int DATA_W     = 64,
  parameter int CTRL_W     = 16,
  parameter int CLEAR_DATA = 0,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt,
  input  logic              stall_cnt_clr
);

  localparam bit ClrData = (CLEAR_DATA != 0);

  logic              accept;
  logic              consume;

  logic              main_v_q;
  logic              main_v_d;
  logic [DATA_W-1:0] main_data_q;
  logic [DATA_W-1:0] main_data_d;
  logic [CTRL_W-1:0] main_ctrl_q;
  logic [CTRL_W-1:0] main_ctrl_d;

  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;

  assign out_valid = main_v_q;
  assign out_data  = main_data_q;
  assign out_ctrl  = main_ctrl_q;
  assign stall_cnt = cnt_q;

  assign consume = main_v_q & out_ready;
  assign accept  = in_valid & in_ready;

`ifdef PIPE_SKID_EN

  logic              skid_v_q;
  logic              skid_v_d;
  logic [DATA_W-1:0] skid_data_q;
  logic [DATA_W-1:0] skid_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q;
  logic [CTRL_W-1:0] skid_ctrl_d;

  // ready comes straight from a flop: no combinational path from out_ready
  assign in_ready = ~skid_v_q;

  always_comb begin
    main_v_d    = main_v_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_v_d    = skid_v_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    if (flush) begin
      main_v_d    = 1'b0;
      main_ctrl_d = '0;
      skid_v_d    = 1'b0;
      skid_ctrl_d = '0;
      if (ClrData) begin
        main_data_d = '0;
        skid_data_d = '0;
      end
    end else if (skid_v_q) begin
      if (consume) begin
        main_v_d    = 1'b1;
        main_data_d = skid_data_q;
        main_ctrl_d = skid_ctrl_q;
        skid_v_d    = 1'b0;
        skid_ctrl_d = '0;
      end
    end else if (accept) begin
      if (!main_v_q || consume) begin
        main_v_d    = 1'b1;
        main_data_d = in_data;
        main_ctrl_d = in_ctrl;
      end else begin
        skid_v_d    = 1'b1;
        skid_data_d = in_data;
        skid_ctrl_d = in_ctrl;
      end
    end else if (consume) begin
      main_v_d    = 1'b0;
      main_ctrl_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      skid_v_q    <= 1'b0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
    end else begin
      skid_v_q    <= skid_v_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
    end
  end

`else

  assign in_ready = ~main_v_q | out_ready;

  always_comb begin
    main_v_d    = main_v_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    if (flush) begin
      main_v_d    = 1'b0;
      main_ctrl_d = '0;
      if (ClrData) begin
        main_data_d = '0;
      end
    end else if (accept) begin
      main_v_d    = 1'b1;
      main_data_d = in_data;
      main_ctrl_d = in_ctrl;
    end else if (consume) begin
      main_v_d    = 1'b0;
      main_ctrl_d = '0;
    end
  end

`endif

  always_comb begin
    cnt_d = cnt_q;
    if (stall_cnt_clr) begin
      cnt_d = '0;
    end else if (main_v_q && !out_ready && !(&cnt_q)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      main_v_q    <= 1'b0;
      main_data_q <= '0;
      main_ctrl_q <= '0;
      cnt_q       <= '0;
    end else begin
      main_v_q    <= main_v_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: default instance plus a
// CLEAR_DATA=1 / CNT_W=4 instance sharing the same stimulus.
module tb_pipe_stage_reg;

`ifdef PIPE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn;
  logic        flush;
  logic        in_valid;
  logic [63:0] in_data;
  logic [15:0] in_ctrl;
  logic        out_ready;
  logic        stall_cnt_clr;

  logic        in_ready;
  logic        out_valid;
  logic [63:0] out_data;
  logic [15:0] out_ctrl;
  logic [15:0] stall_cnt;

  logic        in_ready_b;
  logic        out_valid_b;
  logic [63:0] out_data_b;
  logic [15:0] out_ctrl_b;
  logic [3:0]  stall_cnt_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_stage_reg dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ctrl(out_ctrl),
    .stall_cnt(stall_cnt), .stall_cnt_clr(stall_cnt_clr)
  );

  pipe_stage_reg #(.CLEAR_DATA(1), .CNT_W(4)) dut_b (
    .clk(clk), .rstn(rstn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_b),
    .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid_b), .out_ready(out_ready),
    .out_data(out_data_b), .out_ctrl(out_ctrl_b),
    .stall_cnt(stall_cnt_b), .stall_cnt_clr(stall_cnt_clr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; flush = 1'b0; in_valid = 1'b0;
    in_data = '0; in_ctrl = '0;
    out_ready = 1'b0; stall_cnt_clr = 1'b0;
    #1;
    total++;
    if ({out_valid, out_ctrl, stall_cnt} !== 33'd0) begin
      bad++;
      $display("FAIL reset_state got v=%0b c=%0h n=%0d exp 0",
               out_valid, out_ctrl, stall_cnt);
    end
    total++;
    if (out_data !== 64'd0 || out_data_b !== 64'd0) begin
      bad++;
      $display("FAIL reset_data got %0h/%0h exp 0", out_data, out_data_b);
    end
    @(negedge clk);
    rstn = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready got %0b exp 1", in_ready);
    end
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data  = 64'(i);
      in_ctrl  = 16'(i + 16'h100);
      tick();
      total++;
      if (out_valid !== 1'b1 || out_data !== 64'(i) ||
          out_ctrl !== 16'(i + 16'h100)) begin
        bad++;
        $display("FAIL stream_%0d got v=%0b d=%0h c=%0h exp v=1 d=%0h",
                 i, out_valid, out_data, out_ctrl, i);
      end
    end
    in_valid = 1'b0;
    tick();
    total++;
    if (out_valid !== 1'b0 || out_ctrl !== 16'd0 || stall_cnt !== 16'd0) begin
      bad++;
      $display("FAIL stream_drain got v=%0b c=%0h n=%0d exp 0/0/0",
               out_valid, out_ctrl, stall_cnt);
    end
  endtask

  task automatic test_backpressure();
    logic exp_rdy;
    stall_cnt_clr = 1'b1;
    tick();
    stall_cnt_clr = 1'b0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 64'hA5;
    in_ctrl   = 16'h0003;
    tick();
    in_data = 64'hA6;
    in_ctrl = 16'h0004;
    for (int c = 0; c < 3; c++) begin
      #1;
      exp_rdy = SKID && (c == 0);
      total++;
      if (in_ready !== exp_rdy || out_data !== 64'hA5 || out_valid !== 1'b1) begin
        bad++;
        $display("FAIL bp_hold_%0d got r=%0b d=%0h v=%0b exp r=%0b d=a5 v=1",
                 c, in_ready, out_data, out_valid, exp_rdy);
      end
      tick();
      if (SKID) in_valid = 1'b0;
    end
    total++;
    if (stall_cnt !== 16'd3 || stall_cnt_b !== 4'd3) begin
      bad++;
      $display("FAIL bp_count got %0d/%0d exp 3", stall_cnt, stall_cnt_b);
    end
    out_ready = 1'b1;
    #1;
    total++;
    if (out_data !== 64'hA5 || in_ready !== !SKID) begin
      bad++;
      $display("FAIL bp_release got d=%0h r=%0b exp d=a5 r=%0b",
               out_data, in_ready, !SKID);
    end
    tick();
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || out_data !== 64'hA6 || out_ctrl !== 16'h0004) begin
      bad++;
      $display("FAIL bp_second got v=%0b d=%0h c=%0h exp v=1 d=a6 c=4",
               out_valid, out_data, out_ctrl);
    end
    tick();
    total++;
    if (out_valid !== 1'b0 || out_ctrl !== 16'd0 || stall_cnt !== 16'd3) begin
      bad++;
      $display("FAIL bp_drain got v=%0b c=%0h n=%0d exp 0/0/3",
               out_valid, out_ctrl, stall_cnt);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 64'h1234;
    in_ctrl   = 16'hFFFF;
    tick();
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || out_ctrl !== 16'hFFFF) begin
      bad++;
      $display("FAIL flush_load got v=%0b c=%0h exp v=1 c=ffff",
               out_valid, out_ctrl);
    end
    flush = 1'b1;
    #1;
    total++;
    if (in_ready !== SKID) begin
      bad++;
      $display("FAIL flush_ready got %0b exp %0b", in_ready, SKID);
    end
    tick();
    flush = 1'b0;
    total++;
    if (out_valid !== 1'b0 || out_ctrl !== 16'd0 || out_data !== 64'h1234) begin
      bad++;
      $display("FAIL flush_hold got v=%0b c=%0h d=%0h exp 0/0/1234",
               out_valid, out_ctrl, out_data);
    end
    total++;
    if (out_valid_b !== 1'b0 || out_ctrl_b !== 16'd0 || out_data_b !== 64'd0) begin
      bad++;
      $display("FAIL flush_clear got v=%0b c=%0h d=%0h exp 0/0/0",
               out_valid_b, out_ctrl_b, out_data_b);
    end
  endtask

  task automatic test_flush_accept();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 64'h55;
    in_ctrl   = 16'h0007;
    flush     = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b0 || out_ctrl !== 16'd0 || out_data !== 64'h1234 ||
        out_data_b !== 64'd0) begin
      bad++;
      $display("FAIL flush_acc got v=%0b c=%0h d=%0h/%0h exp 0/0/1234/0",
               out_valid, out_ctrl, out_data, out_data_b);
    end
    in_valid = 1'b1;
    in_data  = 64'h66;
    in_ctrl  = 16'h0009;
    tick();
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || out_data !== 64'h66 || out_ctrl !== 16'h0009) begin
      bad++;
      $display("FAIL flush_next got v=%0b d=%0h c=%0h exp 1/66/9",
               out_valid, out_data, out_ctrl);
    end
    tick();
  endtask

  task automatic test_saturation();
    stall_cnt_clr = 1'b1;
    tick();
    stall_cnt_clr = 1'b0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 64'h77;
    in_ctrl   = 16'h0001;
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 20; c++) tick();
    total++;
    if (stall_cnt !== 16'd20 || stall_cnt_b !== 4'hF) begin
      bad++;
      $display("FAIL sat_count got %0d/%0h exp 20/f", stall_cnt, stall_cnt_b);
    end
    stall_cnt_clr = 1'b1;
    tick();
    stall_cnt_clr = 1'b0;
    total++;
    if (stall_cnt !== 16'd0 || stall_cnt_b !== 4'd0) begin
      bad++;
      $display("FAIL sat_clr got %0d/%0d exp 0", stall_cnt, stall_cnt_b);
    end
    tick();
    total++;
    if (stall_cnt !== 16'd1 || stall_cnt_b !== 4'd1) begin
      bad++;
      $display("FAIL sat_restart got %0d/%0d exp 1", stall_cnt, stall_cnt_b);
    end
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1;
    in_data  = 64'h88;
    in_ctrl  = 16'h0002;
    tick();
    in_valid = 1'b0;
    #2;
    rstn = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || out_ctrl !== 16'd0 || stall_cnt !== 16'd0 ||
        out_data !== 64'd0) begin
      bad++;
      $display("FAIL rst_async got v=%0b c=%0h n=%0d d=%0h exp 0",
               out_valid, out_ctrl, stall_cnt, out_data);
    end
    @(negedge clk);
    rstn = 1'b1;
    tick();
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL rst_release got r=%0b v=%0b exp r=1 v=0",
               in_ready, out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_flush_accept();
    test_saturation();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
